gate_selftest_checker: RTL and testbench

- Hardware self-test sequencer for the two-input bitwise AND gate block.
- Sweeps every operand combination onto the gate inputs, waits a settle window, and compares the gate output against a & b.
- Counts mismatches, captures the first failure, and reports pass/fail.
- Used for on-chip bring-up of gate-level blocks without a simulator bench; `dut_*` ports wire straight to the gate instance.

---
 rtl/gate_selftest_checker.sv | 188 ++++++++++++++++++
 tb/tb_gate_selftest_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_selftest_checker.sv
// gate_selftest_checker: self-test sequencer for a two-input bitwise AND gate.
// Drives every {a,b} operand combination onto the gate, waits a settle window,
// then checks dut_y against dut_a & dut_b. It counts mismatches (saturating),
// captures the first failure, and reports done/pass.
//
// Optional build macro: GATE_SELFTEST_STOP_ON_FAIL_EN
//   defined   - the first mismatch ends the run right after capture and count
//   undefined - every vector of every pass is checked
//
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous reset, active-high
//   start           - run request, level-sampled while idle or done
//   dut_a, dut_b    - registered operands driven to the gate under test
//   dut_y           - gate output under test
//   busy            - run in progress
//   done            - run finished; held until the next accepted start or rst
//   pass            - done with err_count == 0
//   err_count       - saturating mismatch count
//   first_err_vec   - {a,b} of the first mismatch
//   first_err_y     - dut_y observed at the first mismatch
//   first_err_valid - first_err_* hold captured data
module gate_selftest_checker #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned N_PASSES      = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   first_err_vec,
  output logic [WIDTH-1:0]     first_err_y,
  output logic                 first_err_valid
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         state, state_d;
  logic [VW-1:0]      vec, vec_d;
  logic [PW-1:0]      pass_idx, pass_idx_d;
  logic [CW-1:0]      settle_cnt, settle_cnt_d;
  logic [WIDTH-1:0]   dut_a_d, dut_b_d;
  logic               busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_count_d;
  logic [VW-1:0]      first_err_vec_d;
  logic [WIDTH-1:0]   first_err_y_d;
  logic               first_err_valid_d;
  logic               mismatch_c;

  assign mismatch_c = (dut_y != (dut_a & dut_b));

  // Next-state and next-output logic
  always_comb begin
    state_d           = state;
    vec_d             = vec;
    pass_idx_d        = pass_idx;
    settle_cnt_d      = settle_cnt;
    dut_a_d           = dut_a;
    dut_b_d           = dut_b;
    busy_d            = busy;
    done_d            = done;
    pass_d            = pass;
    err_count_d       = err_count;
    first_err_vec_d   = first_err_vec;
    first_err_y_d     = first_err_y;
    first_err_valid_d = first_err_valid;

    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE && busy) begin
          // First cycle in DONE: park the gate inputs and publish the result
          dut_a_d = '0;
          dut_b_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count == '0);
        end else if (start) begin
          err_count_d       = '0;
          first_err_vec_d   = '0;
          first_err_y_d     = '0;
          first_err_valid_d = 1'b0;
          vec_d             = '0;
          pass_idx_d        = '0;
          busy_d            = 1'b1;
          done_d            = 1'b0;
          pass_d            = 1'b0;
          state_d           = S_DRIVE;
        end
      end

      S_DRIVE: begin
        dut_a_d      = vec[VW-1:WIDTH];
        dut_b_d      = vec[WIDTH-1:0];
        settle_cnt_d = CW'(SETTLE_CYCLES);
        state_d      = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_cnt <= CW'(1)) begin
          settle_cnt_d = '0;
          state_d      = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt - CW'(1);
        end
      end

      S_CHECK: begin
        if (mismatch_c) begin
          if (err_count != '1) begin
            err_count_d = err_count + ERR_W'(1);
          end
          if (!first_err_valid) begin
            first_err_vec_d   = {dut_a, dut_b};
            first_err_y_d     = dut_y;
            first_err_valid_d = 1'b1;
          end
        end
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
        if (mismatch_c) begin
          state_d = S_DONE;
        end else
`endif
        if (vec != '1) begin
          vec_d   = vec + VW'(1);
          state_d = S_DRIVE;
        end else if (pass_idx < PW'(N_PASSES - 1)) begin
          pass_idx_d = pass_idx + PW'(1);
          vec_d      = '0;
          state_d    = S_DRIVE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      vec             <= '0;
      pass_idx        <= '0;
      settle_cnt      <= '0;
      dut_a           <= '0;
      dut_b           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_y     <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state           <= state_d;
      vec             <= vec_d;
      pass_idx        <= pass_idx_d;
      settle_cnt      <= settle_cnt_d;
      dut_a           <= dut_a_d;
      dut_b           <= dut_b_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_count       <= err_count_d;
      first_err_vec   <= first_err_vec_d;
      first_err_y     <= first_err_y_d;
      first_err_valid <= first_err_valid_d;
    end
  end

endmodule

// File: tb/tb_gate_selftest_checker.sv
// Scoreboard bench for gate_selftest_checker: the stimulus queues the expected
// run result, and monitors compare it when done rises.
module tb_gate_selftest_checker;

  localparam int unsigned W  = 1;
  localparam int unsigned EW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_s;
  int   mode;

  logic [W-1:0]   a, b, y;
  logic           busy, done, pass_o, fev;
  logic [EW-1:0]  ec;
  logic [2*W-1:0] fvec;
  logic [W-1:0]   fy;

  logic [W-1:0]   a_s, b_s, y_s;
  logic           busy_s, done_s, pass_s, fev_s;
  logic [EW-1:0]  ec_s;
  logic [2*W-1:0] fvec_s;
  logic [W-1:0]   fy_s;

  // Gate model: 0 = correct AND, 1 = stuck-at-0, 2 = stuck-at-1
  assign y   = (mode == 0) ? (a & b) : (mode == 1) ? '0 : '1;
  assign y_s = '1;

  gate_selftest_checker #(.WIDTH(W), .SETTLE_CYCLES(2), .N_PASSES(1), .ERR_W(EW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_a(a), .dut_b(b), .dut_y(y),
    .busy(busy), .done(done), .pass(pass_o), .err_count(ec),
    .first_err_vec(fvec), .first_err_y(fy), .first_err_valid(fev));

  gate_selftest_checker #(.WIDTH(W), .SETTLE_CYCLES(2), .N_PASSES(300), .ERR_W(EW)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .dut_a(a_s), .dut_b(b_s), .dut_y(y_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(ec_s),
    .first_err_vec(fvec_s), .first_err_y(fy_s), .first_err_valid(fev_s));

  typedef struct {
    int err; int vec; int fy; int valid; int pass; int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_qs[$];
  exp_t em, ems;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int t0 = 0, t0s = 0;
  logic prev_done = 1'b0, prev_done_s = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic exp_t mk(int err, int vec, int fyv, int valid, int p, int cyc);
    exp_t e;
    e.err = err; e.vec = vec; e.fy = fyv; e.valid = valid; e.pass = p; e.cyc = cyc;
    return e;
  endfunction

  // Monitor for the single-pass instance
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        em = exp_q.pop_front();
        chk("done_cycle", edge_n - t0, em.cyc);
        chk("err_count", int'(ec), em.err);
        chk("first_err_vec", int'(fvec), em.vec);
        chk("first_err_y", int'(fy), em.fy);
        chk("first_err_valid", int'(fev), em.valid);
        chk("pass", int'(pass_o), em.pass);
        chk("busy_at_done", int'(busy), 0);
        chk("dut_ab_at_done", int'({a, b}), 0);
      end
    end
    prev_done = done;
  end

  // Monitor for the 300-pass saturation instance
  always @(negedge clk) begin
    if (done_s && !prev_done_s) begin
      if (exp_qs.size() == 0) begin
        chk("sat_unexpected_done", 1, 0);
      end else begin
        ems = exp_qs.pop_front();
        chk("sat_done_cycle", edge_n - t0s, ems.cyc);
        chk("sat_err_count", int'(ec_s), ems.err);
        chk("sat_first_err_vec", int'(fvec_s), ems.vec);
        chk("sat_first_err_y", int'(fy_s), ems.fy);
        chk("sat_first_err_valid", int'(fev_s), ems.valid);
        chk("sat_pass", int'(pass_s), ems.pass);
      end
    end
    prev_done_s = done_s;
  end

  // One-cycle start pulse; t0 is the index of the edge that samples it
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    t0 = edge_n + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int b_seen);
    int n;
    n = 0;
    b_seen = 0;
    while ((exp_q.size() != 0 || exp_qs.size() != 0) && n < budget) begin
      @(negedge clk);
      if (busy && b == 1'b1) b_seen = 1;
      n++;
    end
    if (exp_q.size() != 0 || exp_qs.size() != 0) begin
      chk("run_timeout", n, -1);
      exp_q.delete();
      exp_qs.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass_o), 0);
    chk({tag, "_err_count"}, int'(ec), 0);
    chk({tag, "_first_err_vec"}, int'(fvec), 0);
    chk({tag, "_first_err_y"}, int'(fy), 0);
    chk({tag, "_first_err_valid"}, int'(fev), 0);
    chk({tag, "_dut_ab"}, int'({a, b}), 0);
  endtask

  initial begin
    int bs;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset_sat_busy", int'(busy_s), 0);
    chk("reset_sat_err_count", int'(ec_s), 0);
    rst = 1'b0;
    @(negedge clk);

    // Correct gate: vectors 00,01,10,11 at edges 1,5,9,13; done at 17
    mode = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 17));
    launch();
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      wait_edge(t0 + 1 + 4 * i);
      chk("driven_vector", int'({a, b}), i);
    end
    wait_idle(100, bs);

    // Stuck-at-0: only vector 11 mismatches
    mode = 1;
    exp_q.push_back(mk(1, 3, 0, 1, 0, 17));
    launch();
    wait_idle(100, bs);

    // Stuck-at-1: vectors 00,01,10 mismatch
    mode = 2;
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
    exp_q.push_back(mk(1, 0, 1, 1, 0, 5));
`else
    exp_q.push_back(mk(3, 0, 1, 1, 0, 17));
`endif
    launch();
    wait_idle(100, bs);
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
    chk("vec01_never_driven", bs, 0);
`else
    chk("vec01_driven", bs, 1);
`endif

    // start re-pulsed mid-run (sampled at edge 3) is ignored
    mode = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 17));
    launch();
    wait_edge(t0 + 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100, bs);

    // Reset sampled at edge 6 aborts the run
    launch();
    wait_edge(t0 + 5);
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_vec01", int'({a, b}), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrun_reset");
    repeat (3) @(negedge clk);
    chk("idle_after_reset_busy", int'(busy), 0);
    chk("idle_after_reset_ab", int'({a, b}), 0);

    // Fresh start after the reset
    exp_q.push_back(mk(0, 0, 0, 0, 1, 17));
    launch();
    wait_idle(100, bs);

    // 300 passes of stuck-at-1: 900 mismatches saturate at 255
    @(negedge clk);
    start_s = 1'b1;
    t0s = edge_n + 1;
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
    exp_qs.push_back(mk(1, 0, 1, 1, 0, 5));
`else
    exp_qs.push_back(mk(255, 0, 1, 1, 0, 4801));
`endif
    @(negedge clk);
    start_s = 1'b0;
    chk("sat_busy_after_start", int'(busy_s), 1);
    wait_idle(6000, bs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
